// File: rtl/cvxif_coproc_pkg.sv
// rtl/cvxif_coproc_pkg.sv - CV-X-IF types, slot record and predecode helper for the multi-issue coprocessor
package cvxif_coproc_pkg;

  localparam int X_NUM_RS          = 3;
  localparam int X_ID_WIDTH        = 4;
  localparam int X_RFR_WIDTH       = 32;
  localparam int MaxLatWidth       = 16;
  localparam int DefaultNumEntries = 4;
  localparam int DefaultLatWidth   = 4;

  localparam logic [6:0] OpcCustom0 = 7'b0001011;
  localparam logic [6:0] OpcCustom1 = 7'b0101011;

  typedef struct packed {
    logic [15:0]           instr;
    logic [1:0]            mode;
    logic [X_ID_WIDTH-1:0] id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef struct packed {
    logic [31:0]                           instr;
    logic [1:0]                            mode;
    logic [X_ID_WIDTH-1:0]                 id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
    logic [X_NUM_RS-1:0]                   rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [1:0]            size;
    logic [31:0]           wdata;
    logic                  last;
    logic                  spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFR_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef enum logic [1:0] {FREE, ISSUED, COMMITTED, DONE} slot_state_e;

  typedef struct packed {
    slot_state_e            state;
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFR_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [MaxLatWidth-1:0] cnt;
  } slot_t;

  // custom-0 writes a result back, custom-1 is accepted but has no writeback
  function automatic x_issue_resp_t predecode(input logic [6:0] opcode);
    x_issue_resp_t r;
    r = '0;
    case (opcode)
      OpcCustom0: begin
        r.accept    = 1'b1;
        r.writeback = 1'b1;
      end
      OpcCustom1: r.accept = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cvxif_coproc_slot.sv
// rtl/cvxif_coproc_slot.sv - one in-flight instruction slot with commit-triggered latency countdown
module cvxif_coproc_slot
  import cvxif_coproc_pkg::*;
#(
  parameter int LatWidth = DefaultLatWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc,
  input  logic [X_ID_WIDTH-1:0]  alloc_id,
  input  logic [X_RFR_WIDTH-1:0] alloc_data,
  input  logic [4:0]             alloc_rd,
  input  logic                   alloc_we,
  input  logic                   commit_match,
  input  logic                   kill,
  input  logic                   pop,
  output slot_t                  slot
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else begin
      case (slot.state)
        FREE: if (alloc) begin
          slot.state <= ISSUED;
          slot.id    <= alloc_id;
          slot.data  <= alloc_data;
          slot.rd    <= alloc_rd;
          slot.we    <= alloc_we;
          slot.cnt   <= '0;
        end
        ISSUED: if (commit_match) begin
          if (kill) begin
            slot.state <= FREE;
          end else begin
            slot.state <= COMMITTED;
            slot.cnt   <= MaxLatWidth'(slot.data[LatWidth-1:0]);
          end
        end
        // the zero test comes first, so the count never wraps below 0
        COMMITTED: begin
          if (slot.cnt == '0) slot.state <= DONE;
          else                slot.cnt   <= slot.cnt - MaxLatWidth'(1);
        end
        DONE: if (pop) slot.state <= FREE;
        default: slot.state <= FREE;
      endcase
    end
  end

endmodule

// File: rtl/cvxif_multi_issue_coprocessor.sv
// rtl/cvxif_multi_issue_coprocessor.sv - multi-entry CV-X-IF coprocessor: lowest-free allocation, lowest-done result arbitration
module cvxif_multi_issue_coprocessor
  import cvxif_coproc_pkg::*;
#(
  parameter int NumEntries = DefaultNumEntries,
  parameter int LatWidth   = DefaultLatWidth,
  parameter int NumRs      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_compressed_valid_i,
  output logic               x_compressed_ready_o,
  input  x_compressed_req_t  x_compressed_req_i,
  output x_compressed_resp_t x_compressed_resp_o,
  input  logic               x_issue_valid_i,
  output logic               x_issue_ready_o,
  input  x_issue_req_t       x_issue_req_i,
  output x_issue_resp_t      x_issue_resp_o,
  input  logic               x_commit_valid_i,
  input  x_commit_t          x_commit_i,
  output logic               x_mem_valid_o,
  input  logic               x_mem_ready_i,
  output x_mem_req_t         x_mem_req_o,
  input  x_mem_resp_t        x_mem_resp_i,
  input  logic               x_mem_result_valid_i,
  input  x_mem_result_t      x_mem_result_i,
  output logic               x_result_valid_o,
  input  logic               x_result_ready_i,
  output x_result_t          x_result_o
);

  localparam int IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  slot_t                  slots [NumEntries];
  logic [NumEntries-1:0]  free;
  logic [NumEntries-1:0]  unused_cnt;
  logic [IdxW-1:0]        alloc_idx;
  logic [IdxW-1:0]        done_idx;
  logic [IdxW-1:0]        sel_idx;
  logic [IdxW-1:0]        hold_idx;
  logic                   done_any;
  logic                   hold_valid;
  logic                   issue_fire;
  logic                   pop_fire;
  logic [X_RFR_WIDTH-1:0] rs_sum;
  logic [4:0]             rd;
  logic                   unused_in;

  assign x_compressed_ready_o = 1'b0;
  assign x_compressed_resp_o  = '0;
  assign x_mem_valid_o        = 1'b0;
  assign x_mem_req_o          = '0;
  assign unused_in = ^{x_compressed_valid_i, x_compressed_req_i, x_mem_ready_i, x_mem_resp_i,
                       x_mem_result_valid_i, x_mem_result_i, x_issue_req_i};

  assign x_issue_resp_o = predecode(x_issue_req_i.instr[6:0]);
  assign rd             = x_issue_req_i.instr[11:7];
  assign issue_fire     = x_issue_valid_i && x_issue_ready_o && x_issue_resp_o.accept;
  assign x_issue_ready_o = |free;

  always_comb begin
    rs_sum = x_issue_req_i.rs[0] + x_issue_req_i.rs[1];
    if (NumRs == 3) rs_sum = rs_sum + x_issue_req_i.rs[2];
  end

  // downward scans leave the lowest matching index in the result
  always_comb begin
    free      = '0;
    alloc_idx = '0;
    done_any  = 1'b0;
    done_idx  = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      free[i] = (slots[i].state == FREE);
      if (slots[i].state == FREE) alloc_idx = IdxW'(i);
      if (slots[i].state == DONE) begin
        done_any = 1'b1;
        done_idx = IdxW'(i);
      end
    end
  end

  // a stalled result keeps its slot even if a lower slot finishes meanwhile
  assign sel_idx          = hold_valid ? hold_idx : done_idx;
  assign x_result_valid_o = hold_valid || done_any;
  assign pop_fire         = x_result_valid_o && x_result_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_idx   <= '0;
    end else begin
      hold_valid <= x_result_valid_o && !x_result_ready_i;
      hold_idx   <= sel_idx;
    end
  end

  always_comb begin
    x_result_o = '0;
    if (x_result_valid_o) begin
      x_result_o.id   = slots[sel_idx].id;
      x_result_o.data = slots[sel_idx].data;
      x_result_o.rd   = slots[sel_idx].rd;
      x_result_o.we   = slots[sel_idx].we;
    end
  end

  for (genvar g = 0; g < NumEntries; g++) begin : g_slot
    cvxif_coproc_slot #(.LatWidth(LatWidth)) u_slot (
      .clk          (clk_i),
      .rst          (rst_i),
      .alloc        (issue_fire && (alloc_idx == IdxW'(g))),
      .alloc_id     (x_issue_req_i.id),
      .alloc_data   (rs_sum),
      .alloc_rd     (rd),
      .alloc_we     (x_issue_resp_o.writeback && (rd != 5'd0)),
      .commit_match (x_commit_valid_i && (slots[g].state == ISSUED) && (slots[g].id == x_commit_i.id)),
      .kill         (x_commit_i.x_commit_kill),
      .pop          (pop_fire && (sel_idx == IdxW'(g))),
      .slot         (slots[g])
    );
    assign unused_cnt[g] = ^slots[g].cnt;
  end

endmodule

// File: tb/tb_cvxif_multi_issue_coprocessor.sv
// tb/tb_cvxif_multi_issue_coprocessor.sv - directed self-checking bench for the multi-issue coprocessor
module tb_cvxif_multi_issue_coprocessor;
  import cvxif_coproc_pkg::*;

  logic               clk;
  logic               rst;
  logic               compressed_ready;
  x_compressed_resp_t compressed_resp;
  logic               issue_valid;
  logic               issue_ready;
  x_issue_req_t       req;
  x_issue_resp_t      resp;
  logic               commit_valid;
  x_commit_t          commit;
  logic               mem_valid;
  x_mem_req_t         mem_req;
  logic               result_valid;
  logic               result_ready;
  x_result_t          result;

  int nchk;
  int npass;
  int n;

  cvxif_multi_issue_coprocessor #(.NumEntries(4), .LatWidth(4), .NumRs(3)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .x_compressed_valid_i (1'b0),
    .x_compressed_ready_o (compressed_ready),
    .x_compressed_req_i   ('0),
    .x_compressed_resp_o  (compressed_resp),
    .x_issue_valid_i      (issue_valid),
    .x_issue_ready_o      (issue_ready),
    .x_issue_req_i        (req),
    .x_issue_resp_o       (resp),
    .x_commit_valid_i     (commit_valid),
    .x_commit_i           (commit),
    .x_mem_valid_o        (mem_valid),
    .x_mem_ready_i        (1'b0),
    .x_mem_req_o          (mem_req),
    .x_mem_resp_i         ('0),
    .x_mem_result_valid_i (1'b0),
    .x_mem_result_i       ('0),
    .x_result_valid_o     (result_valid),
    .x_result_ready_i     (result_ready),
    .x_result_o           (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_wb(input logic [4:0] rd);
    return {20'h0, rd, OpcCustom0};
  endfunction

  task automatic do_issue(input logic [3:0] id, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req.instr = instr_wb(rd);
    req.id    = id;
    req.rs[0] = a;
    req.rs[1] = b;
    req.rs[2] = c;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit.id            = id;
    commit.x_commit_kill = kill;
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  // counts cycles until a result appears, stopping at bound
  task automatic wait_valid(input int bound, output int cnt);
    cnt = 0;
    while (!result_valid && cnt < bound) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    nchk = 0;
    npass = 0;
    rst = 1'b1;
    issue_valid = 1'b0;
    req = '0;
    commit_valid = 1'b0;
    commit = '0;
    result_ready = 1'b1;
    #12;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("tieoffs", 64'({compressed_ready, compressed_resp, mem_valid, mem_req}), 64'd0);
    rst = 1'b0;
    tick();

    // single op: sum 6 -> result 7 cycles after commit
    req.instr = instr_wb(5'd5);
    req.id = 4'd2;
    req.rs[0] = 32'd1;
    req.rs[1] = 32'd2;
    req.rs[2] = 32'd3;
    issue_valid = 1'b1;
    #1;
    chk("single_accept", 64'(resp.accept), 64'd1);
    chk("single_writeback", 64'(resp.writeback), 64'd1);
    tick();
    issue_valid = 1'b0;
    do_commit(4'd2, 1'b0);
    wait_valid(20, n);
    chk("single_latency", 64'(n), 64'd7);
    chk("single_id", 64'(result.id), 64'd2);
    chk("single_data", 64'(result.data), 64'd6);
    chk("single_rd", 64'(result.rd), 64'd5);
    chk("single_we", 64'(result.we), 64'd1);
    chk("single_exc", 64'({result.exc, result.exccode}), 64'd0);
    tick();
    chk("single_popped", 64'(result_valid), 64'd0);
    chk("single_ready", 64'(issue_ready), 64'd1);

    // kill produces no result
    do_issue(4'd1, 5'd5, 32'd0, 32'd0, 32'd0);
    do_commit(4'd1, 1'b1);
    chk("kill_ready", 64'(issue_ready), 64'd1);
    wait_valid(10, n);
    chk("kill_no_result", 64'(n), 64'd10);

    // rejected opcode must not allocate
    req.instr = 32'h0000_0033;
    issue_valid = 1'b1;
    #1;
    chk("reject_accept", 64'(resp.accept), 64'd0);
    tick();
    issue_valid = 1'b0;

    // fill all four slots
    do_issue(4'd4, 5'd5, 32'd0, 32'd0, 32'd0);
    do_issue(4'd5, 5'd5, 32'd0, 32'd0, 32'd0);
    do_issue(4'd6, 5'd5, 32'd0, 32'd0, 32'd0);
    chk("fill3_ready", 64'(issue_ready), 64'd1);
    do_issue(4'd7, 5'd5, 32'd0, 32'd0, 32'd0);
    chk("fill4_ready", 64'(issue_ready), 64'd0);
    do_commit(4'd9, 1'b0);
    chk("unknown_commit", 64'(issue_ready), 64'd0);
    do_commit(4'd6, 1'b1);
    chk("fill_kill_ready", 64'(issue_ready), 64'd1);
    // issue into slot 2 while killing slot 0 in the same cycle
    req.instr = instr_wb(5'd5);
    req.id = 4'd8;
    issue_valid = 1'b1;
    commit.id = 4'd4;
    commit.x_commit_kill = 1'b1;
    commit_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    commit_valid = 1'b0;
    chk("simul_ready", 64'(issue_ready), 64'd1);
    do_issue(4'd10, 5'd5, 32'd0, 32'd0, 32'd0);
    chk("simul_full", 64'(issue_ready), 64'd0);
    do_commit(4'd10, 1'b1);
    do_commit(4'd5, 1'b1);
    do_commit(4'd8, 1'b1);
    do_commit(4'd7, 1'b1);
    chk("drain_ready", 64'(issue_ready), 64'd1);
    wait_valid(5, n);
    chk("drain_no_result", 64'(n), 64'd5);

    // backpressure: two done slots, id 3 held first
    result_ready = 1'b0;
    do_issue(4'd3, 5'd5, 32'd1, 32'd1, 32'd0);
    do_issue(4'd4, 5'd5, 32'd1, 32'd0, 32'd0);
    do_commit(4'd3, 1'b0);
    do_commit(4'd4, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(result_valid), 64'd1);
      chk("bp_id_held", 64'(result.id), 64'd3);
      tick();
    end
    result_ready = 1'b1;
    #1;
    chk("bp_first_data", 64'(result.data), 64'd2);
    tick();
    chk("bp_second_valid", 64'(result_valid), 64'd1);
    chk("bp_second_id", 64'(result.id), 64'd4);
    chk("bp_second_data", 64'(result.data), 64'd1);
    tick();
    chk("bp_empty", 64'(result_valid), 64'd0);

    // hold: slot 1 stalled, slot 0 finishes later but must not overtake
    result_ready = 1'b0;
    do_issue(4'd5, 5'd5, 32'd3, 32'd0, 32'd0);
    do_issue(4'd6, 5'd5, 32'd0, 32'd0, 32'd0);
    do_commit(4'd6, 1'b0);
    do_commit(4'd5, 1'b0);
    chk("hold_first_id", 64'(result.id), 64'd6);
    repeat (5) tick();
    chk("hold_keeps_id", 64'(result.id), 64'd6);
    result_ready = 1'b1;
    #1;
    chk("hold_release_id", 64'(result.id), 64'd6);
    tick();
    chk("hold_next_id", 64'(result.id), 64'd5);
    chk("hold_next_data", 64'(result.data), 64'd3);
    tick();
    chk("hold_empty", 64'(result_valid), 64'd0);

    // out-of-order commit
    do_issue(4'd0, 5'd5, 32'd8, 32'd0, 32'd0);
    do_issue(4'd1, 5'd0, 32'd0, 32'd0, 32'd0);
    do_commit(4'd1, 1'b0);
    do_commit(4'd0, 1'b0);
    chk("ooo_first_valid", 64'(result_valid), 64'd1);
    chk("ooo_first_id", 64'(result.id), 64'd1);
    chk("ooo_first_we", 64'(result.we), 64'd0);
    tick();
    chk("ooo_gap", 64'(result_valid), 64'd0);
    wait_valid(20, n);
    chk("ooo_second_latency", 64'(n + 1), 64'd9);
    chk("ooo_second_id", 64'(result.id), 64'd0);
    chk("ooo_second_data", 64'(result.data), 64'd8);
    tick();

    // reset mid-flight with one done and two counting slots
    result_ready = 1'b0;
    do_issue(4'd1, 5'd5, 32'd0, 32'd0, 32'd0);
    do_issue(4'd2, 5'd5, 32'd10, 32'd0, 32'd0);
    do_issue(4'd3, 5'd5, 32'd10, 32'd0, 32'd0);
    do_commit(4'd1, 1'b0);
    do_commit(4'd2, 1'b0);
    do_commit(4'd3, 1'b0);
    chk("prerst_valid", 64'(result_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_ready", 64'(issue_ready), 64'd1);
    tick();
    rst = 1'b0;
    result_ready = 1'b1;
    tick();
    chk("postrst_ready", 64'(issue_ready), 64'd1);
    wait_valid(20, n);
    chk("postrst_no_stale", 64'(n), 64'd20);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
